// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Master indices as used by the grant index.
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, otherwise the master
// that was not granted last wins. The history only advances on a grant.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       grant_valid
);

  logic last_grant;

  // Pick the winner from the current requests and the grant history.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = M_DMA;
    end else begin
      grant = M_CPU;
    end
  end

  // Remember who was granted; after reset the history points at m1 so m0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= M_DMA;
    end else if (update && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the cpu core (m0) and the DMA/debug loader
// (m1). One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) ->
// ACK (one-cycle ack to the granted master) -> IDLE.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       gnt_idx;
  logic       arb_grant;
  logic       arb_valid;
  logic       arb_update;

  // The arbiter history only moves when IDLE actually issues a grant.
  assign arb_update = (state == IDLE);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({m1_req, m0_req}),
    .update      (arb_update),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Transaction FSM; every output is registered, and the mem_* registers
  // double as the request latch so they are zero whenever not in ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      gnt_idx   <= M_CPU;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state    <= ACCESS;
            gnt_idx  <= arb_grant;
            wait_cnt <= WAIT_INIT;
            mem_en   <= 1'b1;
            busy     <= 1'b1;
            if (arb_grant == M_DMA) begin
              mem_rw    <= m1_rw;
              mem_addr  <= m1_addr;
              mem_wdata <= m1_wdata;
            end else begin
              mem_rw    <= m0_rw;
              mem_addr  <= m0_addr;
              mem_wdata <= m0_wdata;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 8'd0) begin
            state     <= ACK;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            // Read data is valid on the last ACCESS cycle; writes leave rdata alone.
            if (!mem_rw) begin
              if (gnt_idx == M_DMA) begin
                m1_rdata <= mem_rdata;
              end else begin
                m0_rdata <= mem_rdata;
              end
            end
            if (gnt_idx == M_DMA) begin
              m1_ack <= 1'b1;
            end else begin
              m0_ack <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
